rob_ring: RTL and testbench
===========================

Name: rob_ring

Overview:
- Parametrised circular reorder buffer between rename and the architectural register file (ARF) / free list.
- Allocates one renamed instruction per cycle in program order; accepts N_CMP completion writebacks per cycle, indexed by ROB tag.
- Retires up to RETIRE_W completed head entries per cycle, in order, with ALU and store retire paths.
- Supports a full pipeline flush.

Parameters:
- DEPTH, 64, number of entries; power of two, >= 4.
- TAG_W, $clog2(DEPTH), ROB tag width.
- PREG_W, 6, physical register index width.
- XLEN, 32, data/PC width.
- N_CMP, 3, completion ports.
- RETIRE_W, 2, max retires per cycle; 1..4, <= DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all entries next edge.
- alloc_valid  in  1  rename presents an instruction.
- alloc_ready  out  1  ROB can accept (count < DEPTH).
- alloc_tag  out  TAG_W  tag assigned to the current alloc (= tail).
- alloc_dr, alloc_old_dr  in  PREG_W each  new/previous physical destination.
- alloc_has_dr  in  1  instruction writes a register.
- alloc_is_store  in  1  store instruction.
- alloc_pc  in  XLEN  instruction PC.
- cmp_valid  in  N_CMP  per-port completion strobe.
- cmp_tag  in  N_CMP*TAG_W  completing tags.
- cmp_data  in  N_CMP*XLEN  result (address for stores).
- cmp_sdata  in  N_CMP*XLEN  store data (ignored for non-stores).
- ret_valid  out  RETIRE_W  per-slot retire strobe; always contiguous from bit 0.
- ret_dr, ret_old_dr  out  RETIRE_W*PREG_W  ARF write reg / reg to free.
- ret_has_dr, ret_is_store  out  RETIRE_W each.
- ret_data, ret_sdata, ret_pc  out  RETIRE_W*XLEN each.
- count  out  TAG_W+1  occupied entries.
- empty  out  1  count == 0.

Behaviour:
- Reset (rst high at edge): head = tail = count = 0; all valid/done bits cleared. ret_valid = 0 and all ret_* = 0. alloc_ready = 1, empty = 1. Entry payload RAM is not reset.
- Allocate on alloc_valid && alloc_ready:
  - entry[tail] <= {valid=1, done=0, payload}.
  - tail <= tail+1 mod DEPTH.
  - alloc_tag is combinational from tail.
  - Holding alloc_valid while alloc_ready=0 has no effect; rename holds its inputs.
- Complete: for each port p with cmp_valid[p] and entry[cmp_tag[p]].valid, set done=1 and write data/sdata at the edge.
  - Completion to an invalid entry is ignored.
  - Two ports with the same tag in one cycle: the lowest port index wins.
  - Completion and allocation of the same tag in one cycle cannot occur (a tag is not issued before alloc).
- Retire: combinational scan from head. Slot k is eligible iff slots 0..k-1 are eligible and entry[head+k] is valid && done.
  - Eligible slots drive ret_* registered: retire outputs appear one cycle after done is visible at head.
  - Retired entries are cleared, head advances by the number retired.
  - Completion takes effect one cycle before its retire: done written at edge N, ret_valid at edge N+1.
- Count: count_next = count + alloc_fire - n_retire. Alloc and retire in the same cycle are allowed, including when full: alloc_ready reflects pre-retire count, with no same-cycle bypass.
- Wrap-around: pointers wrap modulo DEPTH; full vs empty is distinguished by count.
- Flush: at the edge, behaves like reset for head/tail/count/valid.
  - ret_valid goes to 0 in that same registered cycle; no retire from the flushed cycle.
  - Concurrent alloc and completions are discarded.
  - rst has priority over flush.
- Stores retire with ret_is_store=1. ret_data = address and ret_sdata = data; ret_has_dr is passed through. The downstream ARF ignores ret_dr when has_dr=0.
- No combinational path from cmp_* to alloc_ready.

Decomposition:
- Shared package rob_pkg: rob_entry_t struct {valid, done, has_dr, is_store, dr, old_dr, pc, data, sdata}; constants for the default ROB_DEPTH, PREG_W and XLEN; OPC_STORE = 7'b0100011 for rename-side decode.
- One sub-module, rob_retire_sel: combinational in-order eligibility prefix over RETIRE_W window entries. Outputs the slot mask and retire count.

Test Plan:
- Reset/fill:
  - rst 2 cycles, then 64 allocs, no completions -> tags 0..63.
  - alloc_ready=0 after the 64th; count=64.
  - Extra alloc ignored.
- Out-of-order complete:
  - Alloc tags 0,1,2; complete 2, then 1 (cycle by cycle).
  - -> no retire until tag 0 completes.
  - Then one cycle later ret_valid=2'b11 for tags 0,1; next cycle 2'b01 for tag 2.
- Full + simultaneous:
  - ROB full, head done, alloc_valid held.
  - -> retire 1 that cycle, alloc accepted the next cycle at tag 0 (wrap); count stays 64.
- Port collision: cmp ports 0 and 2 both tag 5, data 0xAAAA / 0xBBBB -> retired ret_data=0xAAAA.
- Store retire: alloc store PC 0x40, complete with data 0x100, sdata 0xDEAD -> ret_is_store=1, ret_data=0x100, ret_sdata=0xDEAD, ret_pc=0x40.
- Flush mid-operation:
  - 10 entries, 3 done, flush asserted with a concurrent alloc and completion.
  - -> next cycle count=0, empty=1, ret_valid=0.
  - The following alloc gets tag 0.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer and its rename-side users.
package rob_pkg;

  localparam int ROB_DEPTH  = 64;
  localparam int ROB_PREG_W = 6;
  localparam int ROB_XLEN   = 32;

  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // Entry layout is sized by the package constants; rob_ring parameters must match them.
  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  has_dr;
    logic                  is_store;
    logic [ROB_PREG_W-1:0] dr;
    logic [ROB_PREG_W-1:0] old_dr;
    logic [ROB_XLEN-1:0]   pc;
    logic [ROB_XLEN-1:0]   data;
    logic [ROB_XLEN-1:0]   sdata;
  } rob_entry_t;

  function automatic logic is_store_op(input logic [6:0] opcode);
    return opcode == OPC_STORE;
  endfunction

endpackage

// File: rtl/rob_ring_if.sv
// Rename/completion/retire bundle between the pipeline and the reorder buffer.
interface rob_ring_if #(
  parameter int TAG_W    = 6,
  parameter int PREG_W   = 6,
  parameter int XLEN     = 32,
  parameter int N_CMP    = 3,
  parameter int RETIRE_W = 2
);
  logic                       alloc_valid;
  logic                       alloc_ready;
  logic [TAG_W-1:0]           alloc_tag;
  logic [PREG_W-1:0]          alloc_dr;
  logic [PREG_W-1:0]          alloc_old_dr;
  logic                       alloc_has_dr;
  logic                       alloc_is_store;
  logic [XLEN-1:0]            alloc_pc;

  logic [N_CMP-1:0]           cmp_valid;
  logic [N_CMP*TAG_W-1:0]     cmp_tag;
  logic [N_CMP*XLEN-1:0]      cmp_data;
  logic [N_CMP*XLEN-1:0]      cmp_sdata;

  logic [RETIRE_W-1:0]        ret_valid;
  logic [RETIRE_W*PREG_W-1:0] ret_dr;
  logic [RETIRE_W*PREG_W-1:0] ret_old_dr;
  logic [RETIRE_W-1:0]        ret_has_dr;
  logic [RETIRE_W-1:0]        ret_is_store;
  logic [RETIRE_W*XLEN-1:0]   ret_data;
  logic [RETIRE_W*XLEN-1:0]   ret_sdata;
  logic [RETIRE_W*XLEN-1:0]   ret_pc;

  modport master (
    output alloc_valid, alloc_dr, alloc_old_dr, alloc_has_dr, alloc_is_store, alloc_pc,
    output cmp_valid, cmp_tag, cmp_data, cmp_sdata,
    input  alloc_ready, alloc_tag,
    input  ret_valid, ret_dr, ret_old_dr, ret_has_dr, ret_is_store, ret_data, ret_sdata, ret_pc
  );

  modport slave (
    input  alloc_valid, alloc_dr, alloc_old_dr, alloc_has_dr, alloc_is_store, alloc_pc,
    input  cmp_valid, cmp_tag, cmp_data, cmp_sdata,
    output alloc_ready, alloc_tag,
    output ret_valid, ret_dr, ret_old_dr, ret_has_dr, ret_is_store, ret_data, ret_sdata, ret_pc
  );
endinterface

// File: rtl/rob_retire_sel.sv
// In-order retire eligibility: slot k retires only if every older slot in the window retires too.
module rob_retire_sel #(
  parameter int RETIRE_W = 2,
  parameter int CNT_W    = $clog2(RETIRE_W + 1)
) (
  input  logic [RETIRE_W-1:0] win_valid,
  input  logic [RETIRE_W-1:0] win_done,
  output logic [RETIRE_W-1:0] ret_mask,
  output logic [CNT_W-1:0]    ret_cnt
);

  logic ok;

  always_comb begin
    ok       = 1'b1;
    ret_mask = '0;
    ret_cnt  = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      ok          = ok & win_valid[k] & win_done[k];
      ret_mask[k] = ok;
      ret_cnt     = ret_cnt + CNT_W'(ok);
    end
  end

endmodule

// File: rtl/rob_ring.sv
// Circular reorder buffer: in-order alloc, tagged out-of-order completion, in-order multi-retire.
module rob_ring
  import rob_pkg::*;
#(
  parameter int DEPTH    = ROB_DEPTH,
  parameter int TAG_W    = $clog2(DEPTH),
  parameter int PREG_W   = ROB_PREG_W,
  parameter int XLEN     = ROB_XLEN,
  parameter int N_CMP    = 3,
  parameter int RETIRE_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  rob_ring_if.slave    bus,
  output logic [TAG_W:0] count,
  output logic         empty
);

  localparam int CNT_W = $clog2(RETIRE_W + 1);
  localparam int CW    = TAG_W + 1;

  rob_entry_t          ram_q [DEPTH];
  logic [TAG_W-1:0]    head_q, tail_q;
  logic [TAG_W:0]      count_q;

  rob_entry_t          win       [RETIRE_W];
  logic [TAG_W-1:0]    win_idx   [RETIRE_W];
  logic [TAG_W-1:0]    cmp_tag_a [N_CMP];
  logic [RETIRE_W-1:0] win_valid, win_done, ret_mask;
  logic [CNT_W-1:0]    n_ret;
  logic                alloc_ready, alloc_fire;

  // Ready depends only on registered occupancy, so completions never feed back into it.
  assign alloc_ready     = ~count_q[TAG_W];
  assign alloc_fire      = bus.alloc_valid & alloc_ready;
  assign bus.alloc_ready = alloc_ready;
  assign bus.alloc_tag   = tail_q;
  assign count           = count_q;
  assign empty           = (count_q == '0);

  always_comb begin
    for (int k = 0; k < RETIRE_W; k++) begin
      win_idx[k]   = head_q + TAG_W'(k);
      win[k]       = ram_q[win_idx[k]];
      win_valid[k] = win[k].valid;
      win_done[k]  = win[k].done;
    end
  end

  always_comb begin
    for (int p = 0; p < N_CMP; p++) begin
      cmp_tag_a[p] = bus.cmp_tag[p*TAG_W +: TAG_W];
    end
  end

  rob_retire_sel #(.RETIRE_W(RETIRE_W), .CNT_W(CNT_W)) u_retire_sel (
    .win_valid (win_valid),
    .win_done  (win_done),
    .ret_mask  (ret_mask),
    .ret_cnt   (n_ret)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      bus.ret_valid    <= '0;
      bus.ret_dr       <= '0;
      bus.ret_old_dr   <= '0;
      bus.ret_has_dr   <= '0;
      bus.ret_is_store <= '0;
      bus.ret_data     <= '0;
      bus.ret_sdata    <= '0;
      bus.ret_pc       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ram_q[i].valid <= 1'b0;
        ram_q[i].done  <= 1'b0;
      end
    end else begin
      if (alloc_fire) begin
        ram_q[tail_q] <= '{valid: 1'b1, done: 1'b0,
                           has_dr: bus.alloc_has_dr, is_store: bus.alloc_is_store,
                           dr: bus.alloc_dr, old_dr: bus.alloc_old_dr,
                           pc: bus.alloc_pc, data: '0, sdata: '0};
      end
      // Descending order so the lowest port's write is the one that lands.
      for (int p = N_CMP - 1; p >= 0; p--) begin
        if (bus.cmp_valid[p] && ram_q[cmp_tag_a[p]].valid) begin
          ram_q[cmp_tag_a[p]].done  <= 1'b1;
          ram_q[cmp_tag_a[p]].data  <= bus.cmp_data[p*XLEN +: XLEN];
          ram_q[cmp_tag_a[p]].sdata <= bus.cmp_sdata[p*XLEN +: XLEN];
        end
      end
      bus.ret_valid <= ret_mask;
      for (int k = 0; k < RETIRE_W; k++) begin
        if (ret_mask[k]) begin
          ram_q[win_idx[k]].valid <= 1'b0;
          ram_q[win_idx[k]].done  <= 1'b0;
        end
        bus.ret_dr[k*PREG_W +: PREG_W]     <= ret_mask[k] ? win[k].dr     : '0;
        bus.ret_old_dr[k*PREG_W +: PREG_W] <= ret_mask[k] ? win[k].old_dr : '0;
        bus.ret_has_dr[k]                  <= ret_mask[k] & win[k].has_dr;
        bus.ret_is_store[k]                <= ret_mask[k] & win[k].is_store;
        bus.ret_data[k*XLEN +: XLEN]       <= ret_mask[k] ? win[k].data   : '0;
        bus.ret_sdata[k*XLEN +: XLEN]      <= ret_mask[k] ? win[k].sdata  : '0;
        bus.ret_pc[k*XLEN +: XLEN]         <= ret_mask[k] ? win[k].pc     : '0;
      end
      head_q  <= head_q + TAG_W'(n_ret);
      tail_q  <= tail_q + TAG_W'(alloc_fire);
      count_q <= count_q + CW'(alloc_fire) - CW'(n_ret);
    end
  end

endmodule

// File: tb/tb_rob_ring.sv
// Directed bench for rob_ring: fill, out-of-order completion, full+retire, port collision, store, flush.
module tb_rob_ring;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [6:0] count;
  logic       empty;
  int         total = 0;
  int         bad   = 0;

  rob_ring_if #(.TAG_W(6), .PREG_W(6), .XLEN(32), .N_CMP(3), .RETIRE_W(2)) bus ();

  rob_ring dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .count (count),
    .empty (empty)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_alloc(input logic v, input logic [31:0] pc, input logic st, input logic [5:0] dr);
    bus.alloc_valid    = v;
    bus.alloc_pc       = pc;
    bus.alloc_is_store = st;
    bus.alloc_has_dr   = ~st;
    bus.alloc_dr       = dr;
    bus.alloc_old_dr   = dr + 6'd1;
  endtask

  task automatic set_cmp(input int p, input logic [5:0] tag, input logic [31:0] d, input logic [31:0] sd);
    bus.cmp_valid[p]          = 1'b1;
    bus.cmp_tag[p*6 +: 6]     = tag;
    bus.cmp_data[p*32 +: 32]  = d;
    bus.cmp_sdata[p*32 +: 32] = sd;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    set_alloc(1'b0, 32'h0, 1'b0, 6'd0);
    bus.cmp_valid = '0;
    bus.cmp_tag   = '0;
    bus.cmp_data  = '0;
    bus.cmp_sdata = '0;
    step();
    step();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_ready", 64'(bus.alloc_ready), 64'd1);
    chk("rst_tag", 64'(bus.alloc_tag), 64'd0);
    chk("rst_ret_valid", 64'(bus.ret_valid), 64'd0);
    chk("rst_ret_data", 64'(bus.ret_data), 64'd0);
    rst = 1'b0;

    // fill all 64 entries with no completions
    for (int i = 0; i < 64; i++) begin
      set_alloc(1'b1, 32'(i * 4), 1'b0, 6'(i));
      chk("fill_tag", 64'(bus.alloc_tag), 64'(i));
      step();
    end
    chk("full_ready", 64'(bus.alloc_ready), 64'd0);
    chk("full_count", 64'(count), 64'd64);
    chk("full_empty", 64'(empty), 64'd0);
    step();
    chk("extra_count", 64'(count), 64'd64);
    chk("extra_tag", 64'(bus.alloc_tag), 64'd0);

    // full with head completing while alloc_valid is held
    set_cmp(0, 6'd0, 32'h11, 32'h0);
    step();
    bus.cmp_valid = '0;
    chk("fs_no_ret_yet", 64'(bus.ret_valid), 64'd0);
    chk("fs_count_a", 64'(count), 64'd64);
    step();
    chk("fs_ret_valid", 64'(bus.ret_valid), 64'b01);
    chk("fs_ret_data", 64'(bus.ret_data[31:0]), 64'h11);
    chk("fs_ret_dr", 64'(bus.ret_dr[5:0]), 64'd0);
    chk("fs_ret_old_dr", 64'(bus.ret_old_dr[5:0]), 64'd1);
    chk("fs_count_b", 64'(count), 64'd63);
    chk("fs_ready", 64'(bus.alloc_ready), 64'd1);
    chk("fs_wrap_tag", 64'(bus.alloc_tag), 64'd0);
    step();
    set_alloc(1'b0, 32'h0, 1'b0, 6'd0);
    chk("fs_count_c", 64'(count), 64'd64);
    chk("fs_tail_next", 64'(bus.alloc_tag), 64'd1);
    chk("fs_ret_clear", 64'(bus.ret_valid), 64'd0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_count", 64'(count), 64'd0);

    // out-of-order completion, in-order retire
    for (int i = 0; i < 3; i++) begin
      set_alloc(1'b1, 32'h100 + 32'(i * 4), 1'b0, 6'(10 + i));
      step();
    end
    set_alloc(1'b0, 32'h0, 1'b0, 6'd0);
    set_cmp(1, 6'd2, 32'h22, 32'h0);
    step();
    bus.cmp_valid = '0;
    chk("ooo_after2", 64'(bus.ret_valid), 64'd0);
    set_cmp(0, 6'd1, 32'h21, 32'h0);
    step();
    bus.cmp_valid = '0;
    chk("ooo_after1", 64'(bus.ret_valid), 64'd0);
    step();
    chk("ooo_idle", 64'(bus.ret_valid), 64'd0);
    set_cmp(2, 6'd0, 32'h20, 32'h0);
    step();
    bus.cmp_valid = '0;
    chk("ooo_after0", 64'(bus.ret_valid), 64'd0);
    step();
    chk("ooo_ret2", 64'(bus.ret_valid), 64'b11);
    chk("ooo_data2", 64'(bus.ret_data), {32'h21, 32'h20});
    chk("ooo_pc2", 64'(bus.ret_pc), {32'h104, 32'h100});
    chk("ooo_dr2", 64'(bus.ret_dr), 64'({6'd11, 6'd10}));
    chk("ooo_count2", 64'(count), 64'd1);
    step();
    chk("ooo_ret1", 64'(bus.ret_valid), 64'b01);
    chk("ooo_data1", 64'(bus.ret_data), {32'h0, 32'h22});
    chk("ooo_empty", 64'(empty), 64'd1);
    step();
    chk("ooo_quiet", 64'(bus.ret_valid), 64'd0);

    // completion port collision on tag 5 (tags 3,4,5 allocated)
    for (int i = 0; i < 3; i++) begin
      set_alloc(1'b1, 32'h200 + 32'(i * 4), 1'b0, 6'(20 + i));
      chk("col_tag", 64'(bus.alloc_tag), 64'(3 + i));
      step();
    end
    set_alloc(1'b0, 32'h0, 1'b0, 6'd0);
    set_cmp(0, 6'd5, 32'hAAAA, 32'h0);
    set_cmp(1, 6'd3, 32'h33, 32'h0);
    set_cmp(2, 6'd5, 32'hBBBB, 32'h0);
    step();
    bus.cmp_valid = '0;
    step();
    chk("col_ret3", 64'(bus.ret_valid), 64'b01);
    chk("col_data3", 64'(bus.ret_data[31:0]), 64'h33);
    set_cmp(1, 6'd4, 32'h44, 32'h0);
    step();
    bus.cmp_valid = '0;
    step();
    chk("col_ret45", 64'(bus.ret_valid), 64'b11);
    chk("col_data45", 64'(bus.ret_data), {32'hAAAA, 32'h44});
    chk("col_count", 64'(count), 64'd0);

    // store retire at tag 6
    set_alloc(1'b1, 32'h40, 1'b1, 6'd7);
    chk("st_tag", 64'(bus.alloc_tag), 64'd6);
    step();
    set_alloc(1'b0, 32'h0, 1'b0, 6'd0);
    set_cmp(0, 6'd6, 32'h100, 32'hDEAD);
    step();
    bus.cmp_valid = '0;
    step();
    chk("st_ret_valid", 64'(bus.ret_valid), 64'b01);
    chk("st_is_store", 64'(bus.ret_is_store), 64'b01);
    chk("st_has_dr", 64'(bus.ret_has_dr), 64'b00);
    chk("st_data", 64'(bus.ret_data[31:0]), 64'h100);
    chk("st_sdata", 64'(bus.ret_sdata[31:0]), 64'hDEAD);
    chk("st_pc", 64'(bus.ret_pc[31:0]), 64'h40);

    // flush with 10 entries (tags 7..16), 3 done, concurrent alloc and completion
    for (int i = 0; i < 10; i++) begin
      set_alloc(1'b1, 32'h300 + 32'(i * 4), 1'b0, 6'(30 + i));
      step();
    end
    set_alloc(1'b0, 32'h0, 1'b0, 6'd0);
    chk("fl_count10", 64'(count), 64'd10);
    set_cmp(0, 6'd7, 32'h70, 32'h0);
    set_cmp(1, 6'd8, 32'h80, 32'h0);
    set_cmp(2, 6'd9, 32'h90, 32'h0);
    step();
    bus.cmp_valid = '0;
    flush = 1'b1;
    set_alloc(1'b1, 32'h500, 1'b0, 6'd5);
    set_cmp(0, 6'd10, 32'hA0, 32'h0);
    step();
    flush = 1'b0;
    bus.cmp_valid = '0;
    set_alloc(1'b0, 32'h0, 1'b0, 6'd0);
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_empty", 64'(empty), 64'd1);
    chk("fl_ret_valid", 64'(bus.ret_valid), 64'd0);
    chk("fl_tag", 64'(bus.alloc_tag), 64'd0);
    set_alloc(1'b1, 32'h600, 1'b0, 6'd2);
    step();
    set_alloc(1'b0, 32'h0, 1'b0, 6'd0);
    chk("fl_post_count", 64'(count), 64'd1);
    chk("fl_post_tag", 64'(bus.alloc_tag), 64'd1);
    step();
    chk("fl_post_noret", 64'(bus.ret_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
